// File: rtl/ae350_rst_pkg.sv
// Shared types and helpers for the AE350 reset sequencer: state encodings,
// counter width and the registered reset-output bundle.
package ae350_rst_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_DDR_RST   = 3'd2,
        ST_DDR_INIT  = 3'd3,
        ST_POR_HOLD  = 3'd4,
        ST_HW_HOLD   = 3'd5,
        ST_RUN       = 3'd6,
        ST_FAIL      = 3'd7
    } seq_state_e;

    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic ddr3_rstn;
        logic por_rstn;
        logic hw_rstn;
        logic init_fail;
    } rst_out_t;

    // Done in 64 bits so MAX_RETRY = 2^32-1 does not wrap to zero.
    function automatic int unsigned retry_width(input longint unsigned max_retry);
        return $clog2(max_retry + 64'd1);
    endfunction

    function automatic rst_out_t decode_outputs(input seq_state_e st);
        rst_out_t o;
        o = 4'b0000;
        case (st)
            ST_DDR_INIT, ST_POR_HOLD: o.ddr3_rstn = 1'b1;
            ST_HW_HOLD: begin
                o.ddr3_rstn = 1'b1;
                o.por_rstn  = 1'b1;
            end
            ST_RUN: begin
                o.ddr3_rstn = 1'b1;
                o.por_rstn  = 1'b1;
                o.hw_rstn   = 1'b1;
            end
            ST_FAIL: o.init_fail = 1'b1;
            default: o = 4'b0000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ae350_bit_sync.sv
// Multi-flop synchronizer for one asynchronous level input; the chain
// resets to RST_VAL so the consumer sees a defined level during reset.
module ae350_bit_sync #(
    parameter int unsigned SYNC_STAGES = 32'd2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    localparam int unsigned STAGES = (SYNC_STAGES < 32'd2) ? 32'd2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_r;

    // shift the raw input through the flop chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= {STAGES{RST_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/ae350_reset_sequencer.sv
// AE350 reset sequencer: PLL lock, DDR3 controller reset and init, then POR and
// HW release; DDR3 init timeouts are retried a bounded number of times.
module ae350_reset_sequencer
    import ae350_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE    = 32'd1024,
    parameter int unsigned DDR_RST_CYCLES = 32'd10000,
    parameter int unsigned INIT_TIMEOUT   = 32'd25000000,
    parameter int unsigned MAX_RETRY      = 32'd3,
    parameter int unsigned POR_DELAY      = 32'd256,
    parameter int unsigned HW_DELAY       = 32'd256,
    parameter int unsigned SYNC_STAGES    = 32'd2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key_rstn,
    input  logic       pll_lock,
    input  logic       ddr3_init_done,
    output logic       ddr3_rstn,
    output logic       por_rstn,
    output logic       hw_rstn,
    output logic       init_fail,
    output logic [2:0] seq_state
);

    localparam int unsigned      RETRY_W      = retry_width(64'(MAX_RETRY));
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE - 32'd1);
    localparam logic [CNT_W-1:0] DDR_RST_LAST = CNT_W'(DDR_RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] POR_LAST     = CNT_W'(POR_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] HW_LAST      = CNT_W'(HW_DELAY - 32'd1);

    logic               key_s;
    logic               lock_s;
    logic               init_s;
    seq_state_e         state_r;
    seq_state_e         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [CNT_W-1:0]   lock_cnt_r;
    logic [CNT_W-1:0]   lock_cnt_nxt_s;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_nxt_s;
    logic               retry_hit_s;
    logic               timed_s;
    rst_out_t           out_r;

    ae350_bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_key_sync (
        .clk(clk), .rstn(rstn), .d(key_rstn), .q(key_s));
    ae350_bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
        .clk(clk), .rstn(rstn), .d(pll_lock), .q(lock_s));
    ae350_bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_init_sync (
        .clk(clk), .rstn(rstn), .d(ddr3_init_done), .q(init_s));

    assign retry_hit_s = (CNT_W'(retry_r) + 32'd1) == MAX_RETRY;
    assign timed_s     = state_r inside {ST_DDR_RST, ST_DDR_INIT, ST_POR_HOLD, ST_HW_HOLD};

    // next state, lock counter and retry decisions; key beats lock loss beats local rules
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = {CNT_W{1'b0}};
        retry_nxt_s    = retry_r;
        if (state_r != ST_RESET && !key_s) begin
            state_nxt_s = ST_WAIT_LOCK;
            retry_nxt_s = {RETRY_W{1'b0}};
        end else if (!lock_s && (timed_s || state_r == ST_RUN)) begin
            state_nxt_s = ST_WAIT_LOCK;
        end else begin
            case (state_r)
                ST_RESET: state_nxt_s = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lock_s && lock_cnt_r == LOCK_LAST) begin
                        state_nxt_s = ST_DDR_RST;
                    end else if (lock_s) begin
                        lock_cnt_nxt_s = lock_cnt_r + 32'd1;
                    end else begin
                        lock_cnt_nxt_s = {CNT_W{1'b0}};
                    end
                end
                ST_DDR_RST: state_nxt_s = (cnt_r == DDR_RST_LAST) ? ST_DDR_INIT : ST_DDR_RST;
                ST_DDR_INIT: begin
                    if (init_s) begin
                        state_nxt_s = ST_POR_HOLD;
                    end else if (cnt_r == INIT_LAST) begin
                        retry_nxt_s = retry_r + RETRY_W'(1'b1);
                        state_nxt_s = retry_hit_s ? ST_FAIL : ST_DDR_RST;
                    end else begin
                        state_nxt_s = ST_DDR_INIT;
                    end
                end
                ST_POR_HOLD: state_nxt_s = (cnt_r == POR_LAST) ? ST_HW_HOLD : ST_POR_HOLD;
                ST_HW_HOLD:  state_nxt_s = (cnt_r == HW_LAST) ? ST_RUN : ST_HW_HOLD;
                ST_RUN:      state_nxt_s = init_s ? ST_RUN : ST_DDR_RST;
                ST_FAIL:     state_nxt_s = ST_FAIL;
                default:     state_nxt_s = ST_RESET;
            endcase
        end
        if (timed_s && state_nxt_s == state_r) begin
            cnt_nxt_s = cnt_r + 32'd1;
        end else begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end
    end

    // state, counters and Moore outputs decoded from the state being entered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_RESET;
            cnt_r      <= {CNT_W{1'b0}};
            lock_cnt_r <= {CNT_W{1'b0}};
            retry_r    <= {RETRY_W{1'b0}};
            out_r      <= 4'b0000;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            retry_r    <= retry_nxt_s;
            out_r      <= decode_outputs(state_nxt_s);
        end
    end

    assign ddr3_rstn = out_r.ddr3_rstn;
    assign por_rstn  = out_r.por_rstn;
    assign hw_rstn   = out_r.hw_rstn;
    assign init_fail = out_r.init_fail;
    assign seq_state = state_r;

endmodule
